// File: rtl/eth_tx_buf_pkg.sv
// rtl/eth_tx_buf_pkg.sv - shared types and sizes for the TX packet buffer
package eth_tx_buf_pkg;
    localparam int DATA_WIDTH  = 64;
    localparam int EMPTY_WIDTH = 3;
    localparam int DEPTH       = 512;
    localparam int PKT_DEPTH   = 32;
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int PCNT_W      = $clog2(PKT_DEPTH) + 1;
    localparam int WORD_W      = 1 + EMPTY_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic                   eop;
        logic [EMPTY_WIDTH-1:0] empty;
        logic [DATA_WIDTH-1:0]  data;
    } buf_word_t;

    typedef enum logic [1:0] {IDLE, WR, DROP} wr_state_e;
    typedef enum logic {RIDLE, RSEND} rd_state_e;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction
endpackage

// File: rtl/eth_tx_buf_sdp_ram.sv
// rtl/eth_tx_buf_sdp_ram.sv - simple dual-port RAM, single clock, registered read
module eth_tx_buf_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/eth_tx_avst_pkt_buffer.sv
// rtl/eth_tx_avst_pkt_buffer.sv - store-and-forward TX packet buffer for the MAC AVST port
module eth_tx_avst_pkt_buffer
    import eth_tx_buf_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    input  logic                   in_err,
    output logic                   out_valid,
    input  logic                   out_rdy,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_err,
    output logic [31:0]            stat_pkt_fwd,
    output logic [31:0]            stat_pkt_drop,
    output logic [ADDR_W:0]        fill_words
);
    typedef logic [ADDR_W:0] ptr_t;
    localparam ptr_t FULL_LVL = ptr_t'(DEPTH);
    localparam logic [PCNT_W-1:0] PKT_FULL = PCNT_W'(PKT_DEPTH);

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    ptr_t              wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, base;
    logic [PCNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic              ready_q, rvalid_q, first_q, skid_wp_q, skid_rp_q;
    logic [1:0]        skid_cnt_q, drop_inc;
    logic [31:0]       fwd_q, drop_q;
    buf_word_t         skid0_q, skid1_q, head, wword, ram_rdata;
    logic              commit, ram_we, pop, eop_hs, issue;

    assign in_ready = ready_q && (pkt_cnt_q != PKT_FULL);

    // An sop always restarts at the commit point, which rewinds any open packet.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_inc    = 2'd0;
        commit      = 1'b0;
        ram_we      = 1'b0;
        base        = in_sop ? wr_commit_q : wr_ptr_q;
        wword.eop   = in_eop;
        wword.empty = in_eop ? in_empty : '0;
        wword.data  = in_data;
        if (in_valid && in_ready) begin
            if (in_sop && wr_state_q != IDLE) drop_inc = 2'd1;
            if (in_sop || wr_state_q == WR) begin
                wr_ptr_d = base;
                if ((base - rd_ptr_q) == FULL_LVL) begin
                    wr_state_d = DROP;
                    if (in_eop) begin
                        wr_ptr_d   = wr_commit_q;
                        drop_inc   = drop_inc + 2'd1;
                        wr_state_d = IDLE;
                    end
                end else begin
                    ram_we     = 1'b1;
                    wr_ptr_d   = base + ptr_t'(1);
                    wr_state_d = WR;
                    if (in_eop) begin
                        wr_state_d = IDLE;
                        if (in_err) begin
                            wr_ptr_d = wr_commit_q;
                            drop_inc = drop_inc + 2'd1;
                        end else begin
                            wr_commit_d = base + ptr_t'(1);
                            commit      = 1'b1;
                        end
                    end
                end
            end else if (wr_state_q == DROP && in_eop) begin
                wr_ptr_d   = wr_commit_q;
                drop_inc   = drop_inc + 2'd1;
                wr_state_d = IDLE;
            end
        end
    end

    assign head      = skid_rp_q ? skid1_q : skid0_q;
    assign out_valid = (rd_state_q == RSEND) && (skid_cnt_q != 2'd0);
    assign pop       = out_valid && out_rdy;
    assign eop_hs    = pop && head.eop;
    // Fetch only while the skid is guaranteed a free slot when the word lands.
    assign issue     = (rd_ptr_q != wr_commit_q) &&
                       (({1'b0, skid_cnt_q} + {2'b0, rvalid_q} - {2'b0, pop}) < 3'd2);

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        rd_state_d = rd_state_q;
        if (commit && !eop_hs)      pkt_cnt_d = pkt_cnt_q + PCNT_W'(1);
        else if (!commit && eop_hs) pkt_cnt_d = pkt_cnt_q - PCNT_W'(1);
        case (rd_state_q)
            RIDLE:   if (pkt_cnt_q != '0) rd_state_d = RSEND;
            RSEND:   if (eop_hs && pkt_cnt_d == '0) rd_state_d = RIDLE;
            default: rd_state_d = RIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q  <= IDLE;
            rd_state_q  <= RIDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            ready_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            first_q     <= 1'b1;
            fwd_q       <= '0;
            drop_q      <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_q + {{ADDR_W{1'b0}}, issue};
            pkt_cnt_q   <= pkt_cnt_d;
            ready_q     <= 1'b1;
            rvalid_q    <= issue;
            if (pop) first_q <= head.eop;
            fwd_q       <= sat_add(fwd_q, {1'b0, eop_hs});
            drop_q      <= sat_add(drop_q, drop_inc);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid0_q    <= '0;
            skid1_q    <= '0;
            skid_wp_q  <= 1'b0;
            skid_rp_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
        end else begin
            if (rvalid_q) begin
                if (skid_wp_q) skid1_q <= ram_rdata;
                else           skid0_q <= ram_rdata;
                skid_wp_q <= ~skid_wp_q;
            end
            if (pop) skid_rp_q <= ~skid_rp_q;
            skid_cnt_q <= skid_cnt_q + {1'b0, rvalid_q} - {1'b0, pop};
        end
    end

    eth_tx_buf_sdp_ram #(.WIDTH(WORD_W), .AW(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (base[ADDR_W-1:0]),
        .wdata_i (wword),
        .re_i    (issue),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign out_sop       = out_valid && first_q;
    assign out_eop       = out_valid && head.eop;
    assign out_data      = head.data;
    assign out_empty     = head.empty;
    assign out_err       = 1'b0;
    assign stat_pkt_fwd  = fwd_q;
    assign stat_pkt_drop = drop_q;
    assign fill_words    = wr_ptr_q - rd_ptr_q;
endmodule
